paint_input_ctrl: RTL and testbench

//   Parametrised input front-end for the paint system. Debounces NUM_BTN raw buttons,

---
 rtl/paint_input_ctrl_if.sv | 39 +++
 rtl/paint_input_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_paint_input_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/paint_input_ctrl_if.sv
// Bus bundle for the paint input front-end: raw button/joystick inputs going
// in, debounced buttons, selectors, cursor and strobes coming out.
interface paint_input_ctrl_if #(
    parameter int NUM_BTN   = 3,
    parameter int NUM_TOOLS = 4,
    parameter int NUM_SIZES = 4
);
    localparam int TOOL_W = (NUM_TOOLS > 1) ? $clog2(NUM_TOOLS) : 1;
    localparam int SIZE_W = (NUM_SIZES > 1) ? $clog2(NUM_SIZES) : 1;

    logic [NUM_BTN-1:0] btn;
    logic               draw_en;
    logic [9:0]         joy_x;
    logic [9:0]         joy_y;
    logic               joy_valid;

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [TOOL_W-1:0]  tool_sel;
    logic [SIZE_W-1:0]  size_sel;
    logic [9:0]         cursor_x;
    logic [9:0]         cursor_y;
    logic               draw_stb;
    logic               clear_req;

    // Front-end side: consumes raw inputs, produces the cooked outputs.
    modport slave (
        input  btn, draw_en, joy_x, joy_y, joy_valid,
        output btn_level, btn_press, tool_sel, size_sel,
               cursor_x, cursor_y, draw_stb, clear_req
    );

    // Driver side: board/joystick stimulus and the frame-buffer writer.
    modport master (
        output btn, draw_en, joy_x, joy_y, joy_valid,
        input  btn_level, btn_press, tool_sel, size_sel,
               cursor_x, cursor_y, draw_stb, clear_req
    );
endinterface

// File: rtl/paint_input_ctrl.sv
// Paint input front-end: per-button synchronise + debounce, tool/size
// selector cycling, clear request, and a joystick-driven cursor that moves
// one pixel per movement tick, clamped to the screen.
module paint_input_ctrl #(
    parameter int NUM_BTN    = 3,
    parameter int DEB_CYCLES = 1000000,
    parameter int NUM_TOOLS  = 4,
    parameter int NUM_SIZES  = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int JOY_CENTER = 512,
    parameter int JOY_DEAD   = 64,
    parameter int MOVE_DIV   = 500000
) (
    input  logic              clk,
    input  logic              clr,
    paint_input_ctrl_if.slave pif
);
    localparam int TOOL_W = (NUM_TOOLS > 1) ? $clog2(NUM_TOOLS) : 1;
    localparam int SIZE_W = (NUM_SIZES > 1) ? $clog2(NUM_SIZES) : 1;
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int TICK_W = $clog2(MOVE_DIV);

    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(MOVE_DIV - 1);
    localparam logic [TOOL_W-1:0] TOOL_LAST  = TOOL_W'(NUM_TOOLS - 1);
    localparam logic [SIZE_W-1:0] SIZE_LAST  = SIZE_W'(NUM_SIZES - 1);
    localparam logic [10:0]       JOY_HI     = 11'(JOY_CENTER + JOY_DEAD);
    localparam logic [10:0]       JOY_LO     = 11'(JOY_CENTER - JOY_DEAD);
    localparam logic signed [10:0] X_MAX     = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] Y_MAX     = 11'(SCREEN_H - 1);
    localparam logic [9:0]        X_HOME     = 10'(SCREEN_W / 2);
    localparam logic [9:0]        Y_HOME     = 10'(SCREEN_H / 2);
    localparam logic [9:0]        JOY_REST   = 10'(JOY_CENTER);

    typedef enum logic [1:0] {ST_LOW, ST_RISE, ST_HIGH, ST_FALL} deb_state_t;

    logic [NUM_BTN-1:0] r_btn_meta;
    logic [NUM_BTN-1:0] r_btn_sync;
    logic               r_den_meta;
    logic               r_den_sync;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;

    // Two-flop synchronisers for the raw buttons and the draw enable switch.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_den_meta <= 1'b0;
            r_den_sync <= 1'b0;
        end else begin
            r_btn_meta <= pif.btn;
            r_btn_sync <= r_btn_meta;
            r_den_meta <= pif.draw_en;
            r_den_sync <= r_den_meta;
        end
    end

    // One debounce FSM per button; the counter holds how many consecutive
    // samples of the new level have been seen so far.
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
            deb_state_t       r_state;
            deb_state_t       w_state_next;
            logic [DEB_W-1:0] r_cnt;
            logic [DEB_W-1:0] w_cnt_next;
            logic             r_press;
            logic             w_press_next;

            // Debounce state, stability counter and registered press pulse.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                    r_press <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_press <= w_press_next;
                end
            end

            // Next-state: any sample back at the old level abandons the change.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_press_next = 1'b0;
                case (r_state)
                    ST_LOW: begin
                        if (r_btn_sync[gi]) begin
                            if (DEB_CYCLES <= 1) begin
                                w_state_next = ST_HIGH;
                                w_cnt_next   = '0;
                                w_press_next = 1'b1;
                            end else begin
                                w_state_next = ST_RISE;
                                w_cnt_next   = DEB_W'(1);
                            end
                        end
                    end
                    ST_RISE: begin
                        if (!r_btn_sync[gi]) begin
                            w_state_next = ST_LOW;
                            w_cnt_next   = '0;
                        end else if (r_cnt == DEB_LAST) begin
                            w_state_next = ST_HIGH;
                            w_cnt_next   = '0;
                            w_press_next = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + DEB_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (!r_btn_sync[gi]) begin
                            if (DEB_CYCLES <= 1) begin
                                w_state_next = ST_LOW;
                                w_cnt_next   = '0;
                            end else begin
                                w_state_next = ST_FALL;
                                w_cnt_next   = DEB_W'(1);
                            end
                        end
                    end
                    ST_FALL: begin
                        if (r_btn_sync[gi]) begin
                            w_state_next = ST_HIGH;
                            w_cnt_next   = '0;
                        end else if (r_cnt == DEB_LAST) begin
                            w_state_next = ST_LOW;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + DEB_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = ST_LOW;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            assign w_level[gi] = (r_state == ST_HIGH) || (r_state == ST_FALL);
            assign w_press[gi] = r_press;
        end
    endgenerate

    logic [TOOL_W-1:0] r_tool;
    logic [SIZE_W-1:0] r_size;
    logic              r_clear;

    // Selector cycling and clear request, one cycle after the press pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_tool  <= '0;
            r_size  <= '0;
            r_clear <= 1'b0;
        end else begin
            if (w_press[0]) begin
                r_tool <= (r_tool == TOOL_LAST) ? '0 : r_tool + TOOL_W'(1);
            end
            if (w_press[1]) begin
                r_size <= (r_size == SIZE_LAST) ? '0 : r_size + SIZE_W'(1);
            end
            r_clear <= w_press[2];
        end
    end

    logic [9:0]        r_jx;
    logic [9:0]        r_jy;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    // Joystick sample latch and free-running movement tick divider.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_jx       <= JOY_REST;
            r_jy       <= JOY_REST;
            r_tick_cnt <= '0;
        end else begin
            if (pif.joy_valid) begin
                r_jx <= pif.joy_x;
                r_jy <= pif.joy_y;
            end
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    logic [9:0]         r_cur_x;
    logic [9:0]         r_cur_y;
    logic               r_draw_stb;
    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic signed [10:0] w_x_sum;
    logic signed [10:0] w_y_sum;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;

    // Step direction from the latched sample (screen y grows downward, so a
    // stick pushed up decrements y), then clamp the signed sum to the screen.
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        if ({1'b0, r_jx} > JOY_HI) begin
            w_dx = 11'sd1;
        end else if ({1'b0, r_jx} < JOY_LO) begin
            w_dx = -11'sd1;
        end
        if ({1'b0, r_jy} > JOY_HI) begin
            w_dy = -11'sd1;
        end else if ({1'b0, r_jy} < JOY_LO) begin
            w_dy = 11'sd1;
        end
        w_x_sum = $signed({1'b0, r_cur_x}) + w_dx;
        w_y_sum = $signed({1'b0, r_cur_y}) + w_dy;
        if (w_x_sum < 0) begin
            w_x_next = '0;
        end else if (w_x_sum > X_MAX) begin
            w_x_next = X_MAX[9:0];
        end else begin
            w_x_next = w_x_sum[9:0];
        end
        if (w_y_sum < 0) begin
            w_y_next = '0;
        end else if (w_y_sum > Y_MAX) begin
            w_y_next = Y_MAX[9:0];
        end else begin
            w_y_next = w_y_sum[9:0];
        end
    end

    // Cursor moves on tick; the strobe is registered alongside so it lines
    // up with the freshly updated cursor.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cur_x    <= X_HOME;
            r_cur_y    <= Y_HOME;
            r_draw_stb <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cur_x <= w_x_next;
                r_cur_y <= w_y_next;
            end
            r_draw_stb <= w_tick & r_den_sync;
        end
    end

    assign pif.btn_level = w_level;
    assign pif.btn_press = w_press;
    assign pif.tool_sel  = r_tool;
    assign pif.size_sel  = r_size;
    assign pif.cursor_x  = r_cur_x;
    assign pif.cursor_y  = r_cur_y;
    assign pif.draw_stb  = r_draw_stb;
    assign pif.clear_req = r_clear;
endmodule

// File: tb/tb_paint_input_ctrl.sv
// Testbench for paint_input_ctrl: directed table of joystick vectors,
// hand-written button/clamp/reset sequences, and a randomized phase, all
// checked every cycle against a cycle-count based behavioural model.
module tb_paint_input_ctrl;
    localparam int NB  = 3;
    localparam int DEB = 4;
    localparam int NT  = 3;
    localparam int NS  = 4;
    localparam int MD  = 8;
    localparam int W   = 640;
    localparam int H   = 480;
    localparam int JC  = 512;
    localparam int JD  = 64;

    logic clk = 1'b0;
    logic clr;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    paint_input_ctrl_if #(.NUM_BTN(NB), .NUM_TOOLS(NT), .NUM_SIZES(NS)) pif ();

    paint_input_ctrl #(
        .NUM_BTN(NB), .DEB_CYCLES(DEB), .NUM_TOOLS(NT), .NUM_SIZES(NS),
        .SCREEN_W(W), .SCREEN_H(H), .JOY_CENTER(JC), .JOY_DEAD(JD), .MOVE_DIV(MD)
    ) dut (
        .clk(clk),
        .clr(clr),
        .pif(pif.slave)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_tool, m_size, m_cx, m_cy, m_jx, m_jy, m_cycle;
    bit          m_clear, m_stb, m_dmeta, m_dsync;
    bit [NB-1:0] m_bmeta, m_bsync, m_level, m_press;
    int          m_run[NB];

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int dir(input int v);
        if (v > JC + JD) return 1;
        if (v < JC - JD) return -1;
        return 0;
    endfunction

    task automatic model_reset();
        m_tool = 0; m_size = 0; m_clear = 0; m_stb = 0;
        m_cx = W / 2; m_cy = H / 2; m_jx = JC; m_jy = JC; m_cycle = 0;
        m_dmeta = 0; m_dsync = 0; m_bmeta = '0; m_bsync = '0;
        m_level = '0; m_press = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    // One clock of the model: a level flips after DEB consecutive synchronised
    // samples disagreeing with it; the cursor steps every MD-th cycle after reset.
    task automatic model_step();
        bit [NB-1:0] np;
        np = '0;
        if (m_press[0]) m_tool = (m_tool + 1) % NT;
        if (m_press[1]) m_size = (m_size + 1) % NS;
        m_clear = m_press[2];
        for (int i = 0; i < NB; i++) begin
            if (m_bsync[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i] = ~m_level[i];
                    m_run[i]   = 0;
                    np[i]      = m_level[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_press = np;
        m_bsync = m_bmeta;
        m_bmeta = pif.btn;
        if ((m_cycle % MD) == MD - 1) begin
            m_cx  = clampi(m_cx + dir(m_jx), 0, W - 1);
            m_cy  = clampi(m_cy - dir(m_jy), 0, H - 1);
            m_stb = m_dsync;
        end else begin
            m_stb = 0;
        end
        m_dsync = m_dmeta;
        m_dmeta = pif.draw_en;
        if (pif.joy_valid) begin
            m_jx = int'(pif.joy_x);
            m_jy = int'(pif.joy_y);
        end
        m_cycle++;
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) model_reset();
        else      model_step();
    end

    // Compare all outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        logic [29:0] exp_v, act_v;
        if (clr === 1'b1) begin
            exp_v = {m_level, m_press, 2'(m_tool), 2'(m_size), 10'(m_cx), 10'(m_cy), m_stb, m_clear};
            act_v = {pif.btn_level, pif.btn_press, pif.tool_sel, pif.size_sel,
                     pif.cursor_x, pif.cursor_y, pif.draw_stb, pif.clear_req};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Hold button idx high 10 cycles then low 10; report first press cycle,
    // press count and the cycle clear_req first rose (counted from the edge).
    task automatic press_btn(input int idx, output int first, output int cnt, output int clr_first);
        first = -1; cnt = 0; clr_first = -1;
        pif.btn[idx] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pif.btn_press[idx]) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (pif.clear_req && clr_first < 0) clr_first = k;
            if (k == 10) pif.btn[idx] = 1'b0;
        end
    endtask

    // Reset, then present a joystick sample (latched on the first edge out of reset).
    task automatic restart(input int jx, input int jy, input bit den);
        @(negedge clk);
        clr = 1'b0;
        pif.btn = '0;
        pif.joy_x = 10'(jx);
        pif.joy_y = 10'(jy);
        pif.joy_valid = 1'b1;
        pif.draw_en = den;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        pif.joy_valid = 1'b0;
    endtask

    function automatic int pick_joy();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 447;
            2: return 448;
            3: return 576;
            4: return 577;
            5: return 1023;
            6: return 512;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    typedef struct {
        int jx;
        int jy;
        bit den;
        int ex;
        int ey;
        bit estb;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int f, c, cf, stb_cnt;

        vecs[0] = '{1000, 512, 1'b1, 321, 240, 1'b1};
        vecs[1] = '{0,    512, 1'b1, 319, 240, 1'b1};
        vecs[2] = '{512, 1000, 1'b1, 320, 239, 1'b1};
        vecs[3] = '{512,    0, 1'b1, 320, 241, 1'b1};
        vecs[4] = '{576,  512, 1'b1, 320, 240, 1'b1};
        vecs[5] = '{448,  448, 1'b1, 320, 240, 1'b1};
        vecs[6] = '{577,  447, 1'b1, 321, 241, 1'b1};
        vecs[7] = '{447,  577, 1'b0, 319, 239, 1'b0};
        vecs[8] = '{512,  512, 1'b0, 320, 240, 1'b0};

        clr = 1'b0;
        pif.btn = '0;
        pif.draw_en = 1'b0;
        pif.joy_x = 10'd512;
        pif.joy_y = 10'd512;
        pif.joy_valid = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_cursor_x", int'(pif.cursor_x), 320);
        check("rst_cursor_y", int'(pif.cursor_y), 240);
        check("rst_tool", int'(pif.tool_sel), 0);
        check("rst_size", int'(pif.size_sel), 0);
        check("rst_strobes", int'({pif.draw_stb, pif.clear_req, pif.btn_press}), 0);
        check("rst_level", int'(pif.btn_level), 0);

        // btn[0]: one press 6 cycles after the edge, tool 0->1, wraps after 3.
        press_btn(0, f, c, cf);
        check("press0_latency", f, 6);
        check("press0_count", c, 1);
        check("tool_after_1", int'(pif.tool_sel), 1);
        press_btn(0, f, c, cf);
        check("tool_after_2", int'(pif.tool_sel), 2);
        press_btn(0, f, c, cf);
        check("tool_wrap", int'(pif.tool_sel), 0);

        // btn[2]: clear_req one cycle after the press, cursor untouched.
        press_btn(2, f, c, cf);
        check("clear_latency", cf, 7);
        check("clear_cursor_x", int'(pif.cursor_x), 320);

        // btn[1] glitch 1,0,1,0 each 2 cycles: never accepted.
        c = 0; f = 0;
        for (int k = 0; k < 20; k++) begin
            pif.btn[1] = (k < 8) ? ((k / 2) % 2 == 0) : 1'b0;
            @(negedge clk);
            if (pif.btn_press[1]) c++;
            if (pif.btn_level[1]) f++;
        end
        check("glitch_press", c, 0);
        check("glitch_level", f, 0);
        check("glitch_size", int'(pif.size_sel), 0);

        // Joystick table: one tick after reset from the home position.
        for (int v = 0; v < 9; v++) begin
            restart(vecs[v].jx, vecs[v].jy, vecs[v].den);
            repeat (7) @(negedge clk);
            check($sformatf("vec%0d_x", v), int'(pif.cursor_x), vecs[v].ex);
            check($sformatf("vec%0d_y", v), int'(pif.cursor_y), vecs[v].ey);
            check($sformatf("vec%0d_stb", v), int'(pif.draw_stb), int'(vecs[v].estb));
        end

        // Drive to the bottom-right corner and hold there.
        restart(1000, 0, 1'b1);
        stb_cnt = int'(pif.draw_stb);
        for (int k = 2; k <= 2640; k++) begin
            @(negedge clk);
            if (pif.draw_stb) stb_cnt++;
            if (k == 24) begin
                check("walk_x", int'(pif.cursor_x), 323);
                check("walk_y", int'(pif.cursor_y), 243);
            end
        end
        check("clamp_x", int'(pif.cursor_x), 639);
        check("clamp_y", int'(pif.cursor_y), 479);
        check("clamp_stb_count", stb_cnt, 330);
        stb_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (pif.draw_stb) stb_cnt++;
        end
        check("clamp_hold_x", int'(pif.cursor_x), 639);
        check("clamp_hold_stb", stb_cnt, 1);

        // Randomized phase, checked by the model each cycle.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 5) == 0) pif.btn[b] = ~pif.btn[b];
            end
            pif.joy_valid = ($urandom_range(0, 3) == 0);
            if (pif.joy_valid) begin
                pif.joy_x = 10'(pick_joy());
                pif.joy_y = 10'(pick_joy());
            end
            if ($urandom_range(0, 49) == 0) pif.draw_en = ~pif.draw_en;
        end

        // Reset in the middle of a move: outputs return home immediately.
        @(negedge clk);
        pif.btn = '0;
        pif.joy_x = 10'd1000;
        pif.joy_y = 10'd1000;
        pif.joy_valid = 1'b1;
        @(negedge clk);
        pif.joy_valid = 1'b0;
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("midrst_x", int'(pif.cursor_x), 320);
        check("midrst_y", int'(pif.cursor_y), 240);
        check("midrst_sel", int'({pif.tool_sel, pif.size_sel}), 0);
        check("midrst_out", int'({pif.btn_level, pif.btn_press, pif.draw_stb, pif.clear_req}), 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
